// File: rtl/specinvert_rot_detect.sv
// sc16 register-slice pass-through with a windowed rotation-direction detector driving the invert decision.
// Optional macro SPECINVERT_DET_HYST_EN: det_invert flips only after two consecutive windows agree.
module specinvert_rot_detect #(
  parameter int SAMP_W = 16,
  parameter int ACC_W  = 48,
  parameter int WIN_W  = 32
) (
  input  logic                  ce_clk,
  input  logic                  ce_rst,
  input  logic [2*SAMP_W-1:0]   s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [2*SAMP_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  cfg_enable,
  input  logic [31:0]           cfg_threshold,
  input  logic [WIN_W-1:0]      cfg_window,
  output logic                  det_invert,
  output logic                  det_valid,
  output logic [ACC_W-1:0]      det_metric,
  output logic [31:0]           det_count
);
  localparam int DW = 2 * SAMP_W;
  localparam int TW = DW + 1;

  logic [DW-1:0]           m_data_q, m_data_d, prev_q, prev_d;
  logic                    m_last_q, m_last_d, m_valid_q, m_valid_d, have_prev_q, have_prev_d;
  logic [WIN_W-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0]    p1a_q, p1a_d, p1b_q, p1b_d;
  logic                    p1_valid_q, p1_valid_d, p1_last_q, p1_last_d;
  logic signed [TW-1:0]    term_q, term_d;
  logic                    p2_valid_q, p2_valid_d, p2_last_q, p2_last_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, metric_q, metric_d;
  logic                    dv_q, dv_d, inv_q, inv_d;
  logic [31:0]             wins_q, wins_d;
`ifdef SPECINVERT_DET_HYST_EN
  logic                    agree_q, agree_d;
`endif

  logic                    s_ready_s, accept_s, en_s, win_end_s, dec_hold_s, dec_val_s;
  logic signed [DW-1:0]    cur_i_s, cur_q_s, prv_i_s, prv_q_s;
  logic signed [ACC_W:0]   sum_s, met_s, thr_s;
  logic signed [ACC_W-1:0] sat_s;

  // Handshake, operand decode, saturating accumulate and per-window decision
  always_comb begin
    s_ready_s = !ce_rst && (!m_valid_q || m_axis_tready);
    accept_s  = s_axis_tvalid && s_ready_s;
    en_s      = cfg_enable && (cfg_window != {WIN_W{1'b0}});
    win_end_s = (cnt_q >= (cfg_window - {{(WIN_W-1){1'b0}}, 1'b1}));
    cur_i_s   = DW'($signed(s_axis_tdata[SAMP_W-1:0]));
    cur_q_s   = DW'($signed(s_axis_tdata[DW-1:SAMP_W]));
    prv_i_s   = DW'($signed(prev_q[SAMP_W-1:0]));
    prv_q_s   = DW'($signed(prev_q[DW-1:SAMP_W]));
    sum_s     = $signed({acc_q[ACC_W-1], acc_q}) + $signed({{(ACC_W+1-TW){term_q[TW-1]}}, term_q});
    if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
      sat_s = sum_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_s = sum_s[ACC_W-1:0];
    end
    met_s = {sat_s[ACC_W-1], sat_s};
    thr_s = {{(ACC_W+1-32){1'b0}}, cfg_threshold};
    // ">= +thr" is tested first so that thr=0 with metric=0 decides "not inverted"
    if (met_s >= thr_s) begin
      dec_hold_s = 1'b0;
      dec_val_s  = 1'b0;
    end else if (met_s <= -thr_s) begin
      dec_hold_s = 1'b0;
      dec_val_s  = 1'b1;
    end else begin
      dec_hold_s = 1'b1;
      dec_val_s  = 1'b0;
    end
  end

  // Next-state for the data slice, prev tracker and detector pipeline
  always_comb begin
    m_data_d = m_data_q;  m_last_d = m_last_q;  m_valid_d = m_valid_q;
    prev_d = prev_q;  have_prev_d = have_prev_q;  cnt_d = cnt_q;
    p1a_d = p1a_q;  p1b_d = p1b_q;  p1_valid_d = 1'b0;  p1_last_d = p1_last_q;
    term_d = term_q;  p2_valid_d = 1'b0;  p2_last_d = p2_last_q;
    acc_d = acc_q;  metric_d = metric_q;  dv_d = 1'b0;  inv_d = inv_q;  wins_d = wins_q;
`ifdef SPECINVERT_DET_HYST_EN
    agree_d = agree_q;
`endif
    if (accept_s) begin
      m_data_d    = s_axis_tdata;
      m_last_d    = s_axis_tlast;
      m_valid_d   = 1'b1;
      prev_d      = s_axis_tdata;
      have_prev_d = 1'b1;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
    if (!en_s) begin
      cnt_d = {WIN_W{1'b0}};
      acc_d = {ACC_W{1'b0}};
    end else begin
      p1_valid_d = accept_s;
      p2_valid_d = p1_valid_q;
      p2_last_d  = p1_last_q;
      term_d     = $signed({p1a_q[DW-1], p1a_q}) - $signed({p1b_q[DW-1], p1b_q});
      if (accept_s) begin
        p1_last_d = win_end_s;
        p1a_d     = have_prev_q ? prv_i_s * cur_q_s : {DW{1'b0}};
        p1b_d     = have_prev_q ? prv_q_s * cur_i_s : {DW{1'b0}};
        cnt_d     = win_end_s ? {WIN_W{1'b0}} : cnt_q + {{(WIN_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
      if (p2_valid_q && p2_last_q) begin
        metric_d = sat_s;
        acc_d    = {ACC_W{1'b0}};
        dv_d     = 1'b1;
        wins_d   = wins_q + 32'd1;
`ifdef SPECINVERT_DET_HYST_EN
        if (dec_hold_s || (dec_val_s == inv_q)) begin
          agree_d = 1'b0;
        end else if (agree_q) begin
          inv_d   = dec_val_s;
          agree_d = 1'b0;
        end else begin
          agree_d = 1'b1;
        end
`else
        if (!dec_hold_s) begin
          inv_d = dec_val_s;
        end else begin
          inv_d = inv_q;
        end
`endif
      end else if (p2_valid_q) begin
        acc_d = sat_s;
      end else begin
        acc_d = acc_q;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      m_data_q <= '0;  m_last_q <= 1'b0;  m_valid_q <= 1'b0;
      prev_q <= '0;  have_prev_q <= 1'b0;  cnt_q <= '0;
      p1a_q <= '0;  p1b_q <= '0;  p1_valid_q <= 1'b0;  p1_last_q <= 1'b0;
      term_q <= '0;  p2_valid_q <= 1'b0;  p2_last_q <= 1'b0;
      acc_q <= '0;  metric_q <= '0;  dv_q <= 1'b0;  inv_q <= 1'b0;  wins_q <= 32'd0;
`ifdef SPECINVERT_DET_HYST_EN
      agree_q <= 1'b0;
`endif
    end else begin
      m_data_q <= m_data_d;  m_last_q <= m_last_d;  m_valid_q <= m_valid_d;
      prev_q <= prev_d;  have_prev_q <= have_prev_d;  cnt_q <= cnt_d;
      p1a_q <= p1a_d;  p1b_q <= p1b_d;  p1_valid_q <= p1_valid_d;  p1_last_q <= p1_last_d;
      term_q <= term_d;  p2_valid_q <= p2_valid_d;  p2_last_q <= p2_last_d;
      acc_q <= acc_d;  metric_q <= metric_d;  dv_q <= dv_d;  inv_q <= inv_d;  wins_q <= wins_d;
`ifdef SPECINVERT_DET_HYST_EN
      agree_q <= agree_d;
`endif
    end
  end

  assign s_axis_tready = s_ready_s;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;
  assign det_invert    = inv_q;
  assign det_valid     = dv_q;
  assign det_metric    = metric_q;
  assign det_count     = wins_q;
endmodule

// File: tb/tb_specinvert_rot_detect.sv
// Bench for specinvert_rot_detect: window-sum reference model, pass-through scoreboard and directed tone/DC scenarios.
module tb_specinvert_rot_detect;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tlast, s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tlast, m_tvalid, m_tready;
  logic        cfg_enable;
  logic [31:0] cfg_threshold, cfg_window;
  logic        det_invert, det_valid;
  logic [47:0] det_metric;
  logic [31:0] det_count;

  int n_cmp = 0, n_err = 0;
  bit chk_on = 1'b0, stall_in = 1'b0, stall_out = 1'b0;

  // reference model state (values the DUT must show after the next edge)
  bit          e_dv = 1'b0, e_inv = 1'b0, have_p = 1'b0, agree = 1'b0;
  longint      e_metric = 0, wsum = 0, wcnt = 0, pI = 0, pQ = 0;
  logic [31:0] e_cnt = 32'd0;
  int          ev_due[$];
  longint      ev_met[$];
  logic [32:0] sb[$];
  longint      got[$];
  int          out_cnt = 0;

  specinvert_rot_detect dut (
    .ce_clk(clk), .ce_rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .cfg_enable(cfg_enable), .cfg_threshold(cfg_threshold), .cfg_window(cfg_window),
    .det_invert(det_invert), .det_valid(det_valid), .det_metric(det_metric), .det_count(det_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat48(input longint v);
    if (v > 64'sd140737488355327) return 64'sd140737488355327;
    else if (v < -64'sd140737488355328) return -64'sd140737488355328;
    else return v;
  endfunction

  function automatic logic [31:0] tone(input int n, input int dir);
    real ph;
    int  i, q;
    ph = dir * 2.0 * 3.14159265358979 * n / 64.0;
    i  = $rtoi(22937.0 * $cos(ph));
    q  = $rtoi(22937.0 * $sin(ph));
    return {q[15:0], i[15:0]};
  endfunction

  // window-end effect: count, metric and orientation decision
  task automatic apply_window(input longint m);
    longint thr;
    bit     hold, d;
    thr = longint'(cfg_threshold);
    e_dv = 1'b1;  e_metric = m;  e_cnt = e_cnt + 32'd1;
    hold = 1'b0;  d = 1'b0;
    if (m >= thr) d = 1'b0;
    else if (m <= -thr) d = 1'b1;
    else hold = 1'b1;
`ifdef SPECINVERT_DET_HYST_EN
    if (hold || d == e_inv) agree = 1'b0;
    else if (agree) begin e_inv = d; agree = 1'b0; end
    else agree = 1'b1;
`else
    if (!hold) e_inv = d;
`endif
  endtask

  // every cycle: compare DUT with the model, then advance the model by one edge
  always @(negedge clk) begin
    bit          exp_rdy, acc;
    longint      t, ci, cq;
    logic [32:0] exp_beat;
    exp_rdy = !rst && (!m_tvalid || m_tready);
    if (chk_on) begin
      chk("det_valid", det_valid, e_dv);
      chk("det_metric", $signed(det_metric), e_metric);
      chk("det_invert", det_invert, e_inv);
      chk("det_count", det_count, e_cnt);
      chk("s_axis_tready", s_tready, exp_rdy);
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) chk("extra_output_beat", 1, 0);
        else begin
          exp_beat = sb.pop_front();
          chk("m_axis_beat", {m_tlast, m_tdata}, exp_beat);
          out_cnt++;
        end
      end
    end
    if (det_valid === 1'b1) got.push_back($signed(det_metric));
    acc = s_tvalid && exp_rdy;
    ci = longint'($signed(s_tdata[15:0]));
    cq = longint'($signed(s_tdata[31:16]));
    if (rst) begin
      e_dv = 1'b0;  e_inv = 1'b0;  e_metric = 0;  e_cnt = 32'd0;  agree = 1'b0;
      have_p = 1'b0;  wsum = 0;  wcnt = 0;  ev_due.delete();  ev_met.delete();  sb.delete();
    end else begin
      e_dv = 1'b0;
      if (!(cfg_enable && cfg_window != 32'd0)) begin
        ev_due.delete();  ev_met.delete();  wcnt = 0;  wsum = 0;
      end else begin
        foreach (ev_due[i]) ev_due[i]--;
        if (ev_due.size() > 0 && ev_due[0] == 0) begin
          void'(ev_due.pop_front());
          apply_window(ev_met.pop_front());
        end
        if (acc) begin
          t = have_p ? (pI * cq - pQ * ci) : 0;
          wsum = sat48(wsum + t);
          if (wcnt >= longint'(cfg_window) - 1) begin
            ev_due.push_back(2);  ev_met.push_back(wsum);  wsum = 0;  wcnt = 0;
          end else wcnt++;
        end
      end
      if (acc) begin
        pI = ci;  pQ = cq;  have_p = 1'b1;
        sb.push_back({s_tlast, s_tdata});
      end
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = (stall_out && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit ok;
    int guard;
    if (stall_in) while ($urandom_range(0, 3) == 0) begin s_tvalid = 1'b0; idle(1); end
    s_tvalid = 1'b1;  s_tdata = d;  s_tlast = l;  guard = 0;
    forever begin
      @(negedge clk); ok = s_tready;
      @(posedge clk); #1;
      if (ok) break;
      guard++;
      if (guard > 1000) begin chk("send_timeout", 1, 0); break; end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic chk_range(input string name, input longint v, input longint lo, input longint hi);
    chk(name, (v >= lo && v <= hi) ? 1 : 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;  s_tvalid = 1'b0;  s_tdata = 32'd0;  s_tlast = 1'b0;
    cfg_enable = 1'b1;  cfg_threshold = 32'd1000;  cfg_window = 32'd64;
    idle(3);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_det_count", det_count, 0);
    chk("rst_det_invert", det_invert, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // positive tone: four windows, strongly positive metric
    got.delete();
    for (int n = 0; n < 256; n++) send(tone(n, 1), 1'b0);
    idle(6);
    chk("pos_windows", got.size(), 4);
    if (got.size() == 4) begin
      chk_range("pos_metric_w1", got[0], 64'sd3200000000, 64'sd3333000000);
      for (int w = 1; w < 4; w++) chk_range("pos_metric_w", got[w], 64'sd3267000000, 64'sd3333000000);
    end
    chk("pos_invert", det_invert, 0);
    chk("pos_count", det_count, 4);

    // negative tone: metric strongly negative, orientation flips
    got.delete();
    for (int n = 0; n < 256; n++) send(tone(n, -1), 1'b0);
    idle(6);
    chk("neg_windows", got.size(), 4);
    if (got.size() == 4) begin
      chk_range("neg_metric_w1", got[0], -64'sd3333000000, -64'sd3150000000);
      for (int w = 1; w < 4; w++) chk_range("neg_metric_w", got[w], -64'sd3333000000, -64'sd3267000000);
    end
    chk("neg_invert", det_invert, 1);
    chk("neg_count", det_count, 8);

    // dead band: DC input gives metric 0, decision holds
    cfg_enable = 1'b0;
    send({16'h1000, 16'h1000}, 1'b0);
    cfg_enable = 1'b1;
    got.delete();
    for (int n = 0; n < 128; n++) send({16'h1000, 16'h1000}, 1'b0);
    idle(6);
    chk("dc_windows", got.size(), 2);
    if (got.size() == 2) begin
      chk("dc_metric_w1", got[0], 0);
      chk("dc_metric_w2", got[1], 0);
    end
    chk("dc_invert", det_invert, 1);
    chk("dc_count", det_count, 10);

    // pass-through under random stalls on both sides
    out_cnt = 0;  stall_in = 1'b1;  stall_out = 1'b1;
    for (int n = 0; n < 512; n++) send($urandom(), (n % 64) == 63);
    stall_in = 1'b0;  stall_out = 1'b0;
    idle(10);
    chk("pt_out_beats", out_cnt, 512);
    chk("pt_sb_empty", sb.size(), 0);
    chk("pt_count", det_count, 18);

    // shrinking the window mid-window ends it on the next beat
    for (int n = 0; n < 10; n++) send($urandom(), 1'b0);
    cfg_window = 32'd4;
    send($urandom(), 1'b0);
    idle(6);
    chk("win_shrink_count", det_count, 19);
    cfg_window = 32'd64;

    // reset mid-window discards the partial window
    for (int n = 0; n < 30; n++) send(tone(n, 1), 1'b0);
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", det_count, 0);
    chk("mid_rst_metric", $signed(det_metric), 0);
    chk("mid_rst_invert", det_invert, 0);
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    @(posedge clk); #1;
    for (int n = 0; n < 63; n++) send(tone(n, 1), 1'b0);
    idle(6);
    chk("mid_rst_count_63", det_count, 0);
    send(tone(63, 1), 1'b0);
    idle(6);
    chk("mid_rst_count_64", det_count, 1);

    // disabled detector: no windows, data still passes
    got.delete();  out_cnt = 0;
    cfg_window = 32'd0;
    for (int n = 0; n < 100; n++) send($urandom(), 1'b0);
    cfg_window = 32'd64;  cfg_enable = 1'b0;
    for (int n = 0; n < 100; n++) send($urandom(), 1'b0);
    idle(6);
    cfg_enable = 1'b1;
    idle(2);
    chk("dis_windows", got.size(), 0);
    chk("dis_count", det_count, 1);
    chk("dis_out_beats", out_cnt, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
